fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Parameters
REQ-001 SHALL provide parameter RESET_VECTOR, default 32'h0000_0000, PC value after reset.
REQ-002 SHALL provide parameter TIMEOUT, default 16, maximum BUSY cycles waiting for imem_ack before faulting (1..255).
REQ-003 SHALL provide parameter NOP_INST, default 32'h0000_0013, instruction substituted on fault.

Interface
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst  in  1  reset, synchronous and active-high.
REQ-006 phase_fetch  in  1  state machine is in FETCH phase.
REQ-007 stall_fetch  out  1  holds state machine in FETCH until instruction is captured.
REQ-008 pc_we  in  1  load new PC, from writeback.
REQ-009 pc_wdata  in  32  next PC value.
REQ-010 imem_req  out  1  instruction memory request, held until ack/err/timeout.
REQ-011 imem_addr  out  32  request address, stable while imem_req=1.
REQ-012 imem_ack  in  1  read data valid this cycle.
REQ-013 imem_err  in  1  bus error this cycle; has priority over imem_ack.
REQ-014 imem_rdata  in  32  read data.
REQ-015 inst_out  out  32  captured instruction, held until next capture.
REQ-016 inst_pc  out  32  PC of inst_out.
REQ-017 fetch_fault  out  2  00 ok, 01 misaligned, 10 bus error, 11 timeout; held with inst_out.

Function
REQ-018 SHALL implement states IDLE, BUSY and DONE.
REQ-019 IDLE: on phase_fetch=1 with pc[1:0]==0 -> BUSY, latch imem_addr=pc; with pc[1:0]!=0 -> DONE, capture NOP_INST, fault=01, no request.
REQ-020 imem_req SHALL be 1 exactly while in BUSY (registered; first request cycle = cycle after phase_fetch is first sampled).
REQ-021 BUSY: imem_err=1 -> DONE, inst_out=NOP_INST, fault=10; else imem_ack=1 -> DONE, inst_out=imem_rdata, fault=00.
REQ-022 BUSY: 8-bit wait counter cleared on entry and incremented each BUSY cycle without ack/err; on reaching TIMEOUT -> DONE, inst_out=NOP_INST, fault=11.
REQ-023 On every capture, inst_pc SHALL take the latched imem_addr (or pc for misaligned).
REQ-024 DONE: unconditionally -> IDLE next cycle.
REQ-025 stall_fetch SHALL be combinational: phase_fetch & (state != DONE).
REQ-026 pc SHALL load pc_wdata on any cycle with pc_we=1, in any state; an in-flight request keeps its latched imem_addr.
REQ-027 pc_we in the same cycle as an IDLE->BUSY transition: request uses old pc; new pc applies to next fetch.
REQ-028 imem_ack/imem_err in IDLE or DONE SHALL be ignored (no capture, no state change).
REQ-029 phase_fetch dropping while in BUSY SHALL NOT abort the request; capture completes, then DONE->IDLE.
REQ-030 Fetch latency phase_fetch->stall_fetch low SHALL be (ack cycle index in BUSY)+2 cycles; minimum 2 (ack on first BUSY cycle).

Reset
REQ-031 rst=1 at a rising edge SHALL force state=IDLE, pc=RESET_VECTOR, imem_req=0, imem_addr=0, inst_out=NOP_INST, inst_pc=0, fetch_fault=00, counter=0.
REQ-032 rst during BUSY SHALL abandon the request; imem_req=0 from the next cycle; a late ack is ignored per REQ-028.

Verification
REQ-033 Reset, phase_fetch=1, ack on 1st BUSY cycle with rdata=32'h00A00093 -> imem_req one cycle at addr 0, stall_fetch low 2 cycles after phase_fetch, inst_out=32'h00A00093, inst_pc=0, fault=00.
REQ-034 Ack delayed 5 cycles -> imem_req high 6 cycles, imem_addr constant, stall_fetch high throughout, then capture.
REQ-035 No ack, TIMEOUT=16 -> imem_req drops after 16 BUSY cycles, inst_out=32'h00000013, fault=11.
REQ-036 pc_we=1, pc_wdata=32'h102 then fetch -> no imem_req, fault=01, inst_pc=32'h102, stall released after 1 cycle.
REQ-037 imem_err and imem_ack together -> fault=10, inst_out=NOP_INST.
REQ-038 rst asserted mid-BUSY, ack arrives next cycle -> state IDLE, inst_out=NOP_INST, pc=RESET_VECTOR, no capture.

Source files
------------

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch stage. A three-state machine (IDLE, BUSY, DONE) issues one
// instruction-memory read per FETCH phase and captures the returned word. The
// read is replaced by NOP_INST when the PC is misaligned, when the bus reports
// an error, or when no acknowledge arrives within TIMEOUT cycles. In each of
// those cases the reason is reported on fetch_fault.
//
// Parameters
//   RESET_VECTOR  PC value after reset
//   TIMEOUT       BUSY cycles to wait for imem_ack before faulting (1..255)
//   NOP_INST      instruction substituted on any fault
//
// Ports
//   clk          clock; all state changes on the rising edge
//   rst          synchronous, active-high reset
//   phase_fetch  control FSM is in its FETCH phase
//   stall_fetch  holds the control FSM in FETCH until the capture is done
//   pc_we        load pc from pc_wdata (writeback), accepted in any state
//   pc_wdata     next PC value
//   imem_req     memory request, high exactly while in BUSY
//   imem_addr    request address, stable while imem_req is high
//   imem_ack     read data valid this cycle
//   imem_err     bus error this cycle; takes priority over imem_ack
//   imem_rdata   read data
//   inst_out     captured instruction, held until the next capture
//   inst_pc      PC of inst_out
//   fetch_fault  00 ok, 01 misaligned, 10 bus error, 11 timeout
// ---------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int          TIMEOUT      = 16,
    parameter logic [31:0] NOP_INST     = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        phase_fetch,
    output logic        stall_fetch,
    input  logic        pc_we,
    input  logic [31:0] pc_wdata,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic        imem_err,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst_out,
    output logic [31:0] inst_pc,
    output logic [1:0]  fetch_fault
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] FAULT_OK       = 2'b00;
    localparam logic [1:0] FAULT_MISALIGN = 2'b01;
    localparam logic [1:0] FAULT_BUS      = 2'b10;
    localparam logic [1:0] FAULT_TIMEOUT  = 2'b11;

    // Value of the wait counter on the last BUSY cycle allowed before the
    // timeout fires; the counter starts at 0, so BUSY lasts TIMEOUT cycles.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t      state;
    logic [31:0] pc;
    logic [7:0]  wait_cnt;

    // The stall drops in the DONE cycle, i.e. as soon as inst_out is valid.
    assign stall_fetch = phase_fetch && (state != DONE);

    // NOTE: every register below is updated with non-blocking assignments, so
    // all right-hand sides see the pre-edge values. This is what lets a pc_we
    // on the IDLE->BUSY edge update pc while the request still latches the old pc.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            pc          <= RESET_VECTOR;
            wait_cnt    <= 8'd0;
            imem_req    <= 1'b0;
            imem_addr   <= 32'd0;
            inst_out    <= NOP_INST;
            inst_pc     <= 32'd0;
            fetch_fault <= FAULT_OK;
        end else begin
            // Writeback may redirect the PC at any time; an in-flight request
            // is unaffected because it uses the latched imem_addr.
            if (pc_we) begin
                pc <= pc_wdata;
            end

            case (state)
                IDLE: begin
                    if (phase_fetch) begin
                        if (pc[1:0] == 2'b00) begin
                            state     <= BUSY;
                            imem_req  <= 1'b1;
                            imem_addr <= pc;
                            wait_cnt  <= 8'd0;
                        end else begin
                            // Misaligned: no bus traffic, capture a NOP directly.
                            state       <= DONE;
                            inst_out    <= NOP_INST;
                            inst_pc     <= pc;
                            fetch_fault <= FAULT_MISALIGN;
                        end
                    end
                end

                BUSY: begin
                    if (imem_err) begin
                        state       <= DONE;
                        imem_req    <= 1'b0;
                        inst_out    <= NOP_INST;
                        inst_pc     <= imem_addr;
                        fetch_fault <= FAULT_BUS;
                    end else if (imem_ack) begin
                        state       <= DONE;
                        imem_req    <= 1'b0;
                        inst_out    <= imem_rdata;
                        inst_pc     <= imem_addr;
                        fetch_fault <= FAULT_OK;
                    end else if (wait_cnt == WAIT_LAST) begin
                        state       <= DONE;
                        imem_req    <= 1'b0;
                        inst_out    <= NOP_INST;
                        inst_pc     <= imem_addr;
                        fetch_fault <= FAULT_TIMEOUT;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end

                DONE: begin
                    state <= IDLE;
                end

                default: begin
                    state    <= IDLE;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
//
// Directed bench for fetch_unit. Each fetch pushes its expected capture
// (instruction, PC, fault) onto a scoreboard queue; the entry is popped and
// compared when the DUT releases stall_fetch.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

    localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;
    localparam int          TIMEOUT      = 16;
    localparam logic [31:0] NOP_INST     = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [1:0]  fault;
    } cap_t;

    logic        clk;
    logic        rst;
    logic        phase_fetch;
    logic        stall_fetch;
    logic        pc_we;
    logic [31:0] pc_wdata;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic        imem_err;
    logic [31:0] imem_rdata;
    logic [31:0] inst_out;
    logic [31:0] inst_pc;
    logic [1:0]  fetch_fault;

    int          tests;
    int          fails;
    logic [31:0] pc_model;
    cap_t        exp_q[$];
    int          req_cycles;
    int          lat;

    fetch_unit #(
        .RESET_VECTOR(RESET_VECTOR),
        .TIMEOUT     (TIMEOUT),
        .NOP_INST    (NOP_INST)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .phase_fetch(phase_fetch),
        .stall_fetch(stall_fetch),
        .pc_we      (pc_we),
        .pc_wdata   (pc_wdata),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_err   (imem_err),
        .imem_rdata (imem_rdata),
        .inst_out   (inst_out),
        .inst_pc    (inst_pc),
        .fetch_fault(fetch_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle; inputs are driven and outputs sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic pop_and_check(input string tag);
        cap_t e;
        if (exp_q.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_inst"},  inst_out,              e.inst);
            check({tag, "_pc"},    inst_pc,               e.pc);
            check({tag, "_fault"}, {30'd0, fetch_fault},  {30'd0, e.fault});
        end
    endtask

    // One complete fetch. ack_at is the BUSY cycle index carrying the response
    // (negative: never respond). err raises imem_err, both also raises imem_ack.
    // we_first pulses pc_we on the launch cycle.
    task automatic run_fetch(input string tag, input int ack_at, input bit err,
                             input bit both, input logic [31:0] rdata,
                             input bit we_first, input logic [31:0] wdata,
                             output int reqs, output int cycles);
        cap_t e;
        int   busy_idx;
        bit   done;
        e.pc = pc_model;
        if (pc_model[1:0] != 2'b00) begin
            e.inst = NOP_INST; e.fault = 2'b01;
        end else if (ack_at >= 0 && err) begin
            e.inst = NOP_INST; e.fault = 2'b10;
        end else if (ack_at >= 0) begin
            e.inst = rdata;    e.fault = 2'b00;
        end else begin
            e.inst = NOP_INST; e.fault = 2'b11;
        end
        exp_q.push_back(e);

        reqs = 0; cycles = 0; busy_idx = 0; done = 1'b0;
        phase_fetch = 1'b1;
        if (we_first) begin
            pc_we = 1'b1; pc_wdata = wdata; pc_model = wdata;
        end
        for (int i = 0; i < 64 && !done; i++) begin
            tick();
            pc_we = 1'b0; imem_ack = 1'b0; imem_err = 1'b0;
            cycles++;
            if (!stall_fetch) begin
                done = 1'b1;
            end else if (imem_req) begin
                reqs++;
                check({tag, "_addr"}, imem_addr, e.pc);
                if (busy_idx == ack_at) begin
                    imem_err   = err;
                    imem_ack   = !err || both;
                    imem_rdata = rdata;
                end
                busy_idx++;
            end
        end
        if (!done) check({tag, "_cycle_budget"}, {31'd0, stall_fetch}, 32'd0);
        phase_fetch = 1'b0;
        check({tag, "_req_low_at_done"}, {31'd0, imem_req}, 32'd0);
        pop_and_check(tag);
        tick();   // DONE -> IDLE
    endtask

    initial begin
        tests = 0; fails = 0;
        rst = 1'b1; phase_fetch = 1'b0; pc_we = 1'b0; pc_wdata = 32'd0;
        imem_ack = 1'b0; imem_err = 1'b0; imem_rdata = 32'd0;
        pc_model = RESET_VECTOR;
        tick(); tick();
        rst = 1'b0;

        // Reset state
        check("rst_req",   {31'd0, imem_req},    32'd0);
        check("rst_addr",  imem_addr,            32'd0);
        check("rst_inst",  inst_out,             NOP_INST);
        check("rst_pc",    inst_pc,              32'd0);
        check("rst_fault", {30'd0, fetch_fault}, 32'd0);
        check("rst_stall", {31'd0, stall_fetch}, 32'd0);

        // Ack on first BUSY cycle: one request cycle, 2-cycle latency
        run_fetch("ack0", 0, 1'b0, 1'b0, 32'h00A0_0093, 1'b0, 32'd0, req_cycles, lat);
        check("ack0_reqs", req_cycles, 32'd1);
        check("ack0_lat",  lat,        32'd2);

        // Ack/err while IDLE must be ignored
        imem_ack = 1'b1; imem_err = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        tick();
        imem_ack = 1'b0; imem_err = 1'b0;
        tick();
        check("idle_ack_inst",  inst_out,             32'h00A0_0093);
        check("idle_ack_fault", {30'd0, fetch_fault}, 32'd0);
        check("idle_ack_req",   {31'd0, imem_req},    32'd0);

        // Ack delayed 5 cycles
        run_fetch("ack5", 5, 1'b0, 1'b0, 32'h1234_5678, 1'b0, 32'd0, req_cycles, lat);
        check("ack5_reqs", req_cycles, 32'd6);
        check("ack5_lat",  lat,        32'd7);

        // No response: timeout after TIMEOUT BUSY cycles
        run_fetch("tmo", -1, 1'b0, 1'b0, 32'h0, 1'b0, 32'd0, req_cycles, lat);
        check("tmo_reqs", req_cycles, TIMEOUT);
        check("tmo_lat",  lat,        TIMEOUT + 1);

        // Error and ack together: error wins
        run_fetch("err", 2, 1'b1, 1'b1, 32'hCAFE_F00D, 1'b0, 32'd0, req_cycles, lat);
        check("err_reqs", req_cycles, 32'd3);

        // Misaligned PC: no request, stall released after one cycle
        pc_we = 1'b1; pc_wdata = 32'h0000_0102; pc_model = 32'h0000_0102;
        tick();
        pc_we = 1'b0;
        run_fetch("misal", 0, 1'b0, 1'b0, 32'h0, 1'b0, 32'd0, req_cycles, lat);
        check("misal_reqs", req_cycles, 32'd0);
        check("misal_lat",  lat,        32'd1);

        // pc_we on the launch edge: request uses the old pc, next fetch the new
        pc_we = 1'b1; pc_wdata = 32'h0000_0040; pc_model = 32'h0000_0040;
        tick();
        pc_we = 1'b0;
        run_fetch("we_old", 1, 1'b0, 1'b0, 32'h0000_1111, 1'b1, 32'h0000_0080, req_cycles, lat);
        run_fetch("we_new", 0, 1'b0, 1'b0, 32'h0000_2222, 1'b0, 32'd0, req_cycles, lat);

        // phase_fetch dropping mid-BUSY does not abort the request
        exp_q.push_back('{inst: 32'h0000_3333, pc: pc_model, fault: 2'b00});
        phase_fetch = 1'b1;
        tick();
        phase_fetch = 1'b0;
        tick();
        check("drop_req_held", {31'd0, imem_req}, 32'd1);
        imem_ack = 1'b1; imem_rdata = 32'h0000_3333;
        tick();
        imem_ack = 1'b0;
        check("drop_req_low", {31'd0, imem_req}, 32'd0);
        pop_and_check("drop");
        tick();

        // Reset mid-BUSY, late ack ignored, pc back to RESET_VECTOR
        phase_fetch = 1'b1;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0; phase_fetch = 1'b0;
        pc_model = RESET_VECTOR;
        check("rstb_req", {31'd0, imem_req}, 32'd0);
        imem_ack = 1'b1; imem_rdata = 32'hBAD0_BAD0;
        tick();
        imem_ack = 1'b0;
        check("rstb_inst",  inst_out,             NOP_INST);
        check("rstb_pc",    inst_pc,              32'd0);
        check("rstb_fault", {30'd0, fetch_fault}, 32'd0);
        check("rstb_req2",  {31'd0, imem_req},    32'd0);
        run_fetch("post_rst", 0, 1'b0, 1'b0, 32'h0000_4444, 1'b0, 32'd0, req_cycles, lat);

        check("sb_drained", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
